// File: rtl/dac_serial_rx.sv
// dac_serial_rx: receive end of the DAC serial link.
//
// Oversamples the three-wire (sclk, sync, din) link with the system clock,
// rebuilds each MSB-first frame and splits it into channel address and sample.
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   sclk_in, sync_in, din_in  serial pins (sync active-low frame enable)
//   word_out                last complete frame
//   addr_out / data_out     word_out[WORD_W-1 -: ADDR_W] / word_out[DATA_W-1:0]
//   word_valid              one-cycle pulse when word_out updates
//   frame_err               one-cycle pulse when a frame ends short
//   busy                    high while a frame is open
//   frame_cnt / err_cnt     16-bit wrapping statistics, present only when the
//                           RX_STATS_EN macro is defined (constant 0 otherwise)
//
// Requires SYNC_STAGES >= 2 and ADDR_W + DATA_W <= WORD_W.
module dac_serial_rx #(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_in,
  input  logic              sync_in,
  input  logic              din_in,
  output logic [WORD_W-1:0] word_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              word_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt
);

  localparam int unsigned CntW = $clog2(WORD_W + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Input synchronisers. All chains reset to 0 so that a sync_in already low at
  // reset release is not mistaken for a fresh frame start.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sync_sync_q, din_sync_q;
  logic                   sclk_hist_q, sync_hist_q;
  logic                   sclk_s, sync_s, din_s;
  logic                   sclk_fall, sync_fall, sync_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      sync_sync_q <= '0;
      din_sync_q  <= '0;
      sclk_hist_q <= 1'b0;
      sync_hist_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      sync_sync_q <= {sync_sync_q[SYNC_STAGES-2:0], sync_in};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din_in};
      sclk_hist_q <= sclk_s;
      sync_hist_q <= sync_s;
    end
  end

  // din is only sampled as a level, so it has no history flop.
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sync_s    = sync_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_hist_q & ~sclk_s;
  assign sync_fall = sync_hist_q & ~sync_s;
  assign sync_rise = ~sync_hist_q & sync_s;

  // Frame FSM
  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              load_q, load_d;
  logic              err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        // A coincident sclk_fall is not a data bit: IDLE never captures.
        if (sync_fall) begin
          cnt_d   = '0;
          shift_d = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (sclk_fall) begin
          shift_d = {shift_q[WORD_W-2:0], din_s};
          cnt_d   = cnt_q + 1'b1;
        end
        // The last bit wins over a simultaneous sync_rise.
        if (cnt_d == CntW'(WORD_W)) begin
          state_d = StDone;
          load_d  = 1'b1;
        end else if (sync_rise) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StDone: begin
        // Level test rather than edge so a rise coincident with the last bit
        // (already consumed in SHIFT) still closes the frame.
        if (sync_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [WORD_W-1:0] word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              word_valid_q, frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      load_q       <= 1'b0;
      word_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      load_q       <= load_d;
      word_valid_q <= load_q;
      frame_err_q  <= err_d;
      // load_q marks the first cycle in DONE; shift_q is frozen from here on.
      if (load_q) begin
        word_q <= shift_q;
        addr_q <= shift_q[WORD_W-1 -: ADDR_W];
        data_q <= shift_q[DATA_W-1:0];
      end
    end
  end

  assign word_out   = word_q;
  assign addr_out   = addr_q;
  assign data_out   = data_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != StIdle);

`ifdef RX_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (word_valid_q) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (frame_err_q)  err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_cnt = 16'd0;
  assign err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_dac_serial_rx.sv
module tb_dac_serial_rx;

`ifdef RX_STATS_EN
  localparam int Stats = 1;
`else
  localparam int Stats = 0;
`endif

  logic        clk, rst_n, sclk_in, sync_in, din_in;
  logic [15:0] word_out;
  logic [1:0]  addr_out;
  logic [11:0] data_out;
  logic        word_valid, frame_err, busy;
  logic [15:0] frame_cnt, err_cnt;

  dac_serial_rx #(
    .WORD_W(16), .ADDR_W(2), .DATA_W(12), .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk_in    (sclk_in),
    .sync_in    (sync_in),
    .din_in     (din_in),
    .word_out   (word_out),
    .addr_out   (addr_out),
    .data_out   (data_out),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int          wv_cnt = 0;
  int          fe_cnt = 0;
  int          wv_cyc = 0;
  logic [15:0] words[$];
  always @(negedge clk) begin
    if (word_valid) begin
      wv_cnt++;
      wv_cyc = cyc;
      words.push_back(word_out);
    end
    if (frame_err) fe_cnt++;
  end

  int checks   = 0;
  int failures = 0;
  int fall_cyc = 0;
  int last_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit at sclk = clk/8: din set with the rising edge, captured on the fall.
  task automatic sclk_bit(input logic b);
    sclk_in = 1'b1;
    din_in  = b;
    tick(4);
    sclk_in  = 1'b0;
    fall_cyc = cyc;
    tick(4);
  endtask

  // Opens a frame and sends nbits MSB-first plus extra trailing edges; leaves sync low.
  task automatic send_bits(input logic [15:0] w, input int nbits, input int extra);
    sync_in = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      sclk_bit(w[15-i]);
      if (i == 15) last_cyc = fall_cyc;
    end
    for (int i = 0; i < extra; i++) sclk_bit(1'b1);
  endtask

  task automatic end_frame(input int gap);
    sync_in = 1'b1;
    tick(gap);
  endtask

  int wv0, fe0;

  initial begin
    rst_n = 1'b0; sclk_in = 1'b0; sync_in = 1'b1; din_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);

    // Reset state
    check("rst_word", word_out, 16'h0);
    check("rst_addr", addr_out, 2'b00);
    check("rst_data", data_out, 12'h0);
    check("rst_pulses", {word_valid, frame_err, busy}, 3'b000);
    check("rst_cnts", {frame_cnt, err_cnt}, 32'h0);

    // 1: single frame 0x5A3C
    wv0 = wv_cnt; fe0 = fe_cnt;
    send_bits(16'h5A3C, 16, 0);
    check("t1_busy_open", busy, 1'b1);
    end_frame(6);
    check("t1_word", word_out, 16'h5A3C);
    check("t1_addr", addr_out, 2'b01);
    check("t1_data", data_out, 12'hA3C);
    check("t1_wv_count", wv_cnt - wv0, 1);
    check("t1_latency", wv_cyc - last_cyc, 4);
    check("t1_no_err", fe_cnt - fe0, 0);
    check("t1_busy_closed", busy, 1'b0);

    // 2: short frame, 10 bits
    wv0 = wv_cnt; fe0 = fe_cnt;
    send_bits(16'hFFFF, 10, 0);
    end_frame(6);
    check("t2_err_count", fe_cnt - fe0, 1);
    check("t2_no_wv", wv_cnt - wv0, 0);
    check("t2_word_kept", word_out, 16'h5A3C);
    check("t2_err_cnt", err_cnt, (Stats != 0) ? 16'd1 : 16'd0);
    check("t2_busy", busy, 1'b0);

    // 3: 0xFFFF with 4 trailing edges
    wv0 = wv_cnt; fe0 = fe_cnt;
    send_bits(16'hFFFF, 16, 4);
    end_frame(6);
    check("t3_word", word_out, 16'hFFFF);
    check("t3_wv_count", wv_cnt - wv0, 1);
    check("t3_no_err", fe_cnt - fe0, 0);

    // 4: reset after 8 bits of 0x1234, remaining bits clocked with sync still low
    wv0 = wv_cnt; fe0 = fe_cnt;
    send_bits(16'h1234, 8, 0);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("t4_busy_after_rst", busy, 1'b0);
    for (int i = 8; i < 16; i++) sclk_bit(1'b1);
    check("t4_still_idle", busy, 1'b0);
    end_frame(6);
    check("t4_no_pulses", {wv_cnt - wv0, fe_cnt - fe0}, 0);
    send_bits(16'h8001, 16, 0);
    end_frame(6);
    check("t4_word", word_out, 16'h8001);
    check("t4_addr", addr_out, 2'b10);
    check("t4_data", data_out, 12'h001);
    check("t4_wv_count", wv_cnt - wv0, 1);

    // 5: back-to-back frames from a fresh reset, sync high 2 clk between them
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    words.delete();
    fe0 = fe_cnt;
    send_bits(16'h0001, 16, 0);
    end_frame(2);
    send_bits(16'h0002, 16, 0);
    end_frame(2);
    send_bits(16'h0003, 16, 0);
    end_frame(6);
    check("t5_wv_count", words.size(), 3);
    if (words.size() == 3) begin
      check("t5_word0", words[0], 16'h0001);
      check("t5_word1", words[1], 16'h0002);
      check("t5_word2", words[2], 16'h0003);
    end
    check("t5_no_err", fe_cnt - fe0, 0);
    check("t5_frame_cnt", frame_cnt, (Stats != 0) ? 16'd3 : 16'd0);
    check("t5_err_cnt", err_cnt, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
